softmax_sequencer: RTL and testbench



---
 rtl/softmax_pkg.sv | 24 ++
 rtl/softmax_seq_onehot.sv | 24 ++
 rtl/softmax_sequencer.sv | 252 +++++++++++++++++++++++++
 tb/tb_softmax_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/softmax_pkg.sv
// softmax_pkg: shared constants and types for the softmax control sequencer.
//   DEF_IFM_SIZE : default vector length / number of element registers
//   DEF_SEL_W    : default width of lut_sel and out_index
//   FIFO_RD_LAT  : cycles from IFM FIFO read enable to data valid at its output
//   seq_state_e  : sequencer FSM state encoding
package softmax_pkg;

    localparam int unsigned DEF_IFM_SIZE = 10;
    localparam int unsigned DEF_SEL_W    = 4;
    localparam int unsigned FIFO_RD_LAT  = 1;

    typedef enum logic [3:0] {
        StClr,
        StIdle,
        StLoad,
        StFill,
        StCompute,
        StAcc,
        StCapt,
        StOut,
        StDone
    } seq_state_e;

endpackage

// File: rtl/softmax_seq_onehot.sv
// softmax_seq_onehot: index to one-hot decode with enable, drives the
// element-register load strobes.
//   i_en     : decode enable; output is all zeros when low
//   i_idx    : element index (values >= N decode to all zeros)
//   o_onehot : one-hot register load vector
module softmax_seq_onehot
    import softmax_pkg::*;
#(
    parameter int unsigned N     = DEF_IFM_SIZE,
    parameter int unsigned SEL_W = DEF_SEL_W
) (
    input  logic             i_en,
    input  logic [SEL_W-1:0] i_idx,
    output logic [N-1:0]     o_onehot
);

    always_comb begin
        o_onehot = '0;
        for (int unsigned b = 0; b < N; b++) begin
            o_onehot[b] = i_en && (i_idx == SEL_W'(b));
        end
    end

endmodule

// File: rtl/softmax_sequencer.sv
// softmax_sequencer: control FSM for the softmax datapath. Loads an IFM vector
// into the IFM FIFO, copies it into the element registers, then for every
// output element runs the subtract/LUT/accumulate loop and strobes the result
// into the output register.
// Optional feature: define SOFTMAX_SEQ_STALL_EN to add i_out_ready; the OUT
// state then holds all outputs until downstream accepts the result.
// Ports:
//   clk1, rst_n    : clock, asynchronous active-low reset
//   i_valid_ifm    : IFM word present on datapath input
//   o_ifm_ready    : sequencer accepts i_valid_ifm this cycle
//   i_out_ready    : downstream accepts o_valid_out (stall build only)
//   o_wr_ifm       : FIFO write enable (zero-latency handshake)
//   o_rd_ifm       : FIFO read enable
//   o_wr_clr       : FIFO write-pointer clear
//   o_rd_clr       : FIFO read-pointer clear
//   o_reg_write    : one-hot element-register load
//   o_lut_sel      : subtractor/LUT mux select
//   o_acc_clr      : accumulator loads instead of adds (first term)
//   o_acc_en       : accumulator update enable
//   o_out_capture  : load output register from accumulator
//   o_valid_out    : output register holds result for o_out_index
//   o_out_index    : element index of current result
//   o_busy         : high in every state except IDLE
//   o_end_softmax  : one-cycle pulse after last result handed off
module softmax_sequencer
    import softmax_pkg::*;
#(
    parameter int unsigned IFM_SIZE = DEF_IFM_SIZE,
    parameter int unsigned SEL_W    = DEF_SEL_W
) (
    input  logic                clk1,
    input  logic                rst_n,
    input  logic                i_valid_ifm,
    output logic                o_ifm_ready,
`ifdef SOFTMAX_SEQ_STALL_EN
    input  logic                i_out_ready,
`endif
    output logic                o_wr_ifm,
    output logic                o_rd_ifm,
    output logic                o_wr_clr,
    output logic                o_rd_clr,
    output logic [IFM_SIZE-1:0] o_reg_write,
    output logic [SEL_W-1:0]    o_lut_sel,
    output logic                o_acc_clr,
    output logic                o_acc_en,
    output logic                o_out_capture,
    output logic                o_valid_out,
    output logic [SEL_W-1:0]    o_out_index,
    output logic                o_busy,
    output logic                o_end_softmax
);

    localparam int unsigned CNT_W = SEL_W + 1;
    localparam logic [CNT_W-1:0] N_C       = CNT_W'(IFM_SIZE);
    localparam logic [CNT_W-1:0] N_LAST    = CNT_W'(IFM_SIZE - 1);
    localparam logic [CNT_W-1:0] LAT_C     = CNT_W'(FIFO_RD_LAT);
    // Final FILL cycle: the register load for the last read, no read issued.
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(IFM_SIZE + FIFO_RD_LAT - 1);

    seq_state_e       r_state;
    logic [CNT_W-1:0] r_load_cnt;
    logic [CNT_W-1:0] r_k;
    logic [CNT_W-1:0] r_j;
    logic [CNT_W-1:0] r_i;
    logic             r_ifm_ready;
    logic             r_rd_ifm;
    logic             r_wr_clr;
    logic             r_rd_clr;
    logic             r_wr_en;
    logic [SEL_W-1:0] r_wr_idx;
    logic [SEL_W-1:0] r_lut_sel;
    logic             r_acc_clr;
    logic             r_acc_en;
    logic             r_out_capture;
    logic             r_valid_out;
    logic [SEL_W-1:0] r_out_index;
    logic             r_busy;
    logic             r_end_softmax;

    logic             w_accept;
    logic             w_out_ready;
    logic [CNT_W-1:0] w_k_nxt;
    logic [CNT_W-1:0] w_j_nxt;

`ifdef SOFTMAX_SEQ_STALL_EN
    assign w_out_ready = i_out_ready;
`else
    assign w_out_ready = 1'b1;
`endif

    assign w_accept = i_valid_ifm & r_ifm_ready;
    assign w_k_nxt  = r_k + 1'b1;
    assign w_j_nxt  = r_j + 1'b1;

    // Outputs are registered: each branch sets the values for the cycle spent
    // in the state being entered.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StClr;
            r_load_cnt    <= '0;
            r_k           <= '0;
            r_j           <= '0;
            r_i           <= '0;
            r_ifm_ready   <= 1'b0;
            r_rd_ifm      <= 1'b0;
            r_wr_clr      <= 1'b0;
            r_rd_clr      <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_idx      <= '0;
            r_lut_sel     <= '0;
            r_acc_clr     <= 1'b0;
            r_acc_en      <= 1'b0;
            r_out_capture <= 1'b0;
            r_valid_out   <= 1'b0;
            r_out_index   <= '0;
            r_busy        <= 1'b0;
            r_end_softmax <= 1'b0;
        end else begin
            r_wr_clr      <= 1'b0;
            r_rd_clr      <= 1'b0;
            r_out_capture <= 1'b0;
            r_end_softmax <= 1'b0;
            unique case (r_state)
                // Reset leaves all outputs low, so the clear pulse is raised
                // on the first edge and CLR exits on the second.
                StClr: begin
                    if (!r_wr_clr) begin
                        r_wr_clr <= 1'b1;
                        r_rd_clr <= 1'b1;
                        r_busy   <= 1'b1;
                    end else begin
                        r_state     <= StIdle;
                        r_ifm_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                StIdle: begin
                    if (w_accept) begin
                        r_state    <= StLoad;
                        r_load_cnt <= CNT_W'(1);
                        r_busy     <= 1'b1;
                    end
                end
                StLoad: begin
                    if (w_accept) begin
                        if (r_load_cnt == N_LAST) begin
                            r_state     <= StFill;
                            r_ifm_ready <= 1'b0;
                            r_load_cnt  <= '0;
                            r_k         <= '0;
                            r_rd_ifm    <= 1'b1;
                            r_wr_en     <= 1'b0;
                        end else begin
                            r_load_cnt <= r_load_cnt + 1'b1;
                        end
                    end
                end
                // r_k is the FILL cycle number; register load trails the read
                // by the FIFO read latency.
                StFill: begin
                    if (r_k == FILL_LAST) begin
                        r_state  <= StCompute;
                        r_rd_ifm <= 1'b1;
                        r_wr_en  <= 1'b0;
                        r_wr_idx <= '0;
                        r_i      <= '0;
                    end else begin
                        r_k      <= w_k_nxt;
                        r_rd_ifm <= (w_k_nxt < N_C);
                        r_wr_en  <= (w_k_nxt >= LAT_C);
                        r_wr_idx <= SEL_W'(w_k_nxt - LAT_C);
                        r_rd_clr <= (w_k_nxt == FILL_LAST);
                    end
                end
                StCompute: begin
                    r_state   <= StAcc;
                    r_rd_ifm  <= 1'b0;
                    r_j       <= '0;
                    r_acc_en  <= 1'b1;
                    r_acc_clr <= 1'b1;
                    r_lut_sel <= '0;
                end
                StAcc: begin
                    if (r_j == N_LAST) begin
                        r_state       <= StCapt;
                        r_acc_en      <= 1'b0;
                        r_acc_clr     <= 1'b0;
                        r_lut_sel     <= '0;
                        r_out_capture <= 1'b1;
                    end else begin
                        r_j       <= w_j_nxt;
                        r_lut_sel <= SEL_W'(w_j_nxt);
                        r_acc_clr <= 1'b0;
                    end
                end
                StCapt: begin
                    r_state     <= StOut;
                    r_valid_out <= 1'b1;
                    r_out_index <= SEL_W'(r_i);
                end
                StOut: begin
                    if (w_out_ready) begin
                        r_valid_out <= 1'b0;
                        r_out_index <= '0;
                        if (r_i == N_LAST) begin
                            r_state       <= StDone;
                            r_end_softmax <= 1'b1;
                            r_wr_clr      <= 1'b1;
                            r_rd_clr      <= 1'b1;
                        end else begin
                            r_state  <= StCompute;
                            r_i      <= r_i + 1'b1;
                            r_rd_ifm <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    r_state     <= StIdle;
                    r_ifm_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
                default: begin
                    r_state <= StClr;
                end
            endcase
        end
    end

    softmax_seq_onehot #(
        .N     (IFM_SIZE),
        .SEL_W (SEL_W)
    ) u_onehot (
        .i_en     (r_wr_en),
        .i_idx    (r_wr_idx),
        .o_onehot (o_reg_write)
    );

    assign o_ifm_ready   = r_ifm_ready;
    assign o_wr_ifm      = w_accept;
    assign o_rd_ifm      = r_rd_ifm;
    assign o_wr_clr      = r_wr_clr;
    assign o_rd_clr      = r_rd_clr;
    assign o_lut_sel     = r_lut_sel;
    assign o_acc_clr     = r_acc_clr;
    assign o_acc_en      = r_acc_en;
    assign o_out_capture = r_out_capture;
    assign o_valid_out   = r_valid_out;
    assign o_out_index   = r_out_index;
    assign o_busy        = r_busy;
    assign o_end_softmax = r_end_softmax;

endmodule

// File: tb/tb_softmax_sequencer.sv
// tb_softmax_sequencer: scoreboard bench for softmax_sequencer. The driver
// pushes expected events (register loads, clear pulses, results, end pulse)
// with their cycle numbers; the monitor pops and compares them on negedge.
`timescale 1ns/1ps
module tb_softmax_sequencer;
    import softmax_pkg::*;

    localparam int N  = 10;
    localparam int SW = 4;

    logic          clk1      = 1'b0;
    logic          rst_n     = 1'b0;
    logic          valid_ifm = 1'b0;
`ifdef SOFTMAX_SEQ_STALL_EN
    logic          out_ready = 1'b1;
`endif
    logic          ifm_ready, wr_ifm, rd_ifm, wr_clr, rd_clr;
    logic          acc_clr, acc_en, out_capture, valid_out, busy, end_softmax;
    logic [N-1:0]  reg_write;
    logic [SW-1:0] lut_sel, out_index;
    logic [10+N+2*SW:0] outvec;

    softmax_sequencer #(
        .IFM_SIZE (N),
        .SEL_W    (SW)
    ) dut (
        .clk1          (clk1),
        .rst_n         (rst_n),
        .i_valid_ifm   (valid_ifm),
        .o_ifm_ready   (ifm_ready),
`ifdef SOFTMAX_SEQ_STALL_EN
        .i_out_ready   (out_ready),
`endif
        .o_wr_ifm      (wr_ifm),
        .o_rd_ifm      (rd_ifm),
        .o_wr_clr      (wr_clr),
        .o_rd_clr      (rd_clr),
        .o_reg_write   (reg_write),
        .o_lut_sel     (lut_sel),
        .o_acc_clr     (acc_clr),
        .o_acc_en      (acc_en),
        .o_out_capture (out_capture),
        .o_valid_out   (valid_out),
        .o_out_index   (out_index),
        .o_busy        (busy),
        .o_end_softmax (end_softmax)
    );

    assign outvec = {ifm_ready, wr_ifm, rd_ifm, wr_clr, rd_clr, reg_write, lut_sel,
                     acc_clr, acc_en, out_capture, valid_out, out_index, busy, end_softmax};

    always #5 clk1 = ~clk1;

    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    typedef struct { int idx; int cyc; int dur; } out_t;
    typedef struct { int cyc; logic wr; } clr_t;
    typedef struct { int cyc; logic [N-1:0] val; } rw_t;

    out_t q_out[$];
    clr_t q_clr[$];
    rw_t  q_rw[$];
    int   q_end[$];

    int n_total = 0;
    int n_bad   = 0;
    int n_wr    = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexp(input string name);
        n_total++;
        n_bad++;
        $display("FAIL %s: got unexpected event, expected none (cycle %0d)", name, cyc);
    endtask

    // Monitor
    logic prev_vout = 1'b0;
    int   cur_dur = 0, exp_dur = 0, acc_en_cnt = 0, acc_clr_cnt = 0, rd_cnt = 0;
    out_t m_out;
    clr_t m_clr;
    rw_t  m_rw;
    int   m_end;

    always @(negedge clk1) begin
        if (!rst_n) begin
            prev_vout   = 1'b0;
            cur_dur     = 0;
            acc_en_cnt  = 0;
            acc_clr_cnt = 0;
            rd_cnt      = 0;
        end else begin
            if (wr_ifm) n_wr++;
            if (rd_ifm) rd_cnt++;
            if (acc_en) begin
                chk("lut_sel_seq", lut_sel, acc_en_cnt);
                chk("acc_clr_first", acc_clr, (acc_en_cnt == 0) ? 1 : 0);
                acc_en_cnt++;
            end else begin
                chk("lut_sel_idle", lut_sel, 0);
            end
            if (acc_clr) acc_clr_cnt++;
            if (reg_write != '0) begin
                if (q_rw.size() == 0) unexp("reg_write");
                else begin
                    m_rw = q_rw.pop_front();
                    chk("reg_write_val", reg_write, m_rw.val);
                    chk("reg_write_cyc", cyc, m_rw.cyc);
                end
            end
            if (wr_clr || rd_clr) begin
                if (q_clr.size() == 0) unexp("clr_pulse");
                else begin
                    m_clr = q_clr.pop_front();
                    chk("clr_cyc", cyc, m_clr.cyc);
                    chk("clr_wr", wr_clr, m_clr.wr);
                    chk("clr_rd", rd_clr, 1);
                end
            end
            if (valid_out && !prev_vout) begin
                if (q_out.size() == 0) unexp("valid_out");
                else begin
                    m_out = q_out.pop_front();
                    chk("out_index", out_index, m_out.idx);
                    chk("out_cyc", cyc, m_out.cyc);
                    chk("acc_en_per_elem", acc_en_cnt, N);
                    chk("acc_clr_per_elem", acc_clr_cnt, 1);
                    exp_dur = m_out.dur;
                end
                acc_en_cnt  = 0;
                acc_clr_cnt = 0;
                cur_dur     = 0;
            end
            if (valid_out) begin
                cur_dur++;
                chk("out_quiet", {acc_en, rd_ifm}, 0);
            end
            if (!valid_out && prev_vout) chk("vout_dur", cur_dur, exp_dur);
            if (end_softmax) begin
                if (q_end.size() == 0) unexp("end_softmax");
                else begin
                    m_end = q_end.pop_front();
                    chk("end_cyc", cyc, m_end);
                    chk("rd_ifm_per_run", rd_cnt, 2 * N);
                end
                rd_cnt = 0;
            end
            prev_vout = valid_out;
        end
    end

    // Driver helpers: called at posedge+1 with the DUT in IDLE.
    task automatic load_vec(input int gap, output int t_last);
        n_wr = 0;
        t_last = 0;
        for (int w = 0; w < N; w++) begin
            valid_ifm = 1'b1;
            t_last = cyc;
            @(posedge clk1); #1;
            valid_ifm = 1'b0;
            if (w != N - 1) begin
                repeat (gap) begin @(posedge clk1); #1; end
                if (gap > 0 && w == N - 2) begin
                    chk("gap_ready_held", ifm_ready, 1);
                    chk("gap_no_fill", rd_ifm, 0);
                end
            end
        end
    endtask

    task automatic push_expect(input int t, input int stall_idx, input int stall_len);
        rw_t  r;
        clr_t c;
        out_t o;
        int   tot;
        for (int k = 0; k < N; k++) begin
            r.cyc = t + 2 + k;
            r.val = '0;
            r.val[k] = 1'b1;
            q_rw.push_back(r);
        end
        c.cyc = t + N + 1;
        c.wr  = 1'b0;
        q_clr.push_back(c);
        for (int i = 0; i < N; i++) begin
            o.idx = i;
            o.cyc = t + 2 * N + 4 + i * (N + 3) + ((stall_idx >= 0 && i > stall_idx) ? stall_len : 0);
            o.dur = (i == stall_idx) ? stall_len + 1 : 1;
            q_out.push_back(o);
        end
        tot = t + (N + 1) + N * (N + 3) + 1 + ((stall_idx >= 0) ? stall_len : 0);
        c.cyc = tot;
        c.wr  = 1'b1;
        q_clr.push_back(c);
        q_end.push_back(tot);
    endtask

    task automatic wait_idle(input int budget);
        for (int c = 0; c < budget && q_end.size() != 0; c++) @(posedge clk1);
        #1;
        if (q_end.size() != 0) begin
            unexp("end_timeout");
            q_end.delete();
            q_out.delete();
            q_clr.delete();
            q_rw.delete();
        end
        chk("idle_ready", ifm_ready, 1);
        chk("idle_busy", busy, 0);
    endtask

    task automatic wait_cyc(input int target);
        for (int c = 0; c < 500 && cyc < target; c++) begin @(posedge clk1); #1; end
        if (cyc != target) unexp("wait_cyc_timeout");
    endtask

    task automatic release_reset();
        clr_t c;
        c.cyc = cyc + 1;
        c.wr  = 1'b1;
        q_clr.push_back(c);
        rst_n = 1'b1;
        @(posedge clk1); #1;
        chk("clr_pulse_wr", wr_clr, 1);
        chk("clr_pulse_rd", rd_clr, 1);
        chk("clr_not_ready", ifm_ready, 0);
        @(posedge clk1); #1;
        chk("post_clr_wr", wr_clr, 0);
        chk("post_clr_ready", ifm_ready, 1);
        chk("post_clr_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish by 200000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        #1;
        chk("reset_outputs", outvec, 0);
        release_reset();

        // Back-to-back load and full unstalled run
        load_vec(0, t);
        chk("ready_drop", ifm_ready, 0);
        chk("busy_fill", busy, 1);
        chk("wr_count_b2b", n_wr, N);
        push_expect(t, -1, 0);
        wait_idle(400);

        // Gapped load; valid_ifm during compute must be ignored
        load_vec(3, t);
        chk("wr_count_gap", n_wr, N);
        push_expect(t, -1, 0);
        valid_ifm = 1'b1;
        repeat (20) begin @(posedge clk1); #1; end
        valid_ifm = 1'b0;
        wait_idle(400);
        chk("wr_ignored", n_wr, N);

`ifdef SOFTMAX_SEQ_STALL_EN
        // Stall 5 cycles on element 3
        load_vec(0, t);
        push_expect(t, 3, 5);
        wait_cyc(t + 63);
        out_ready = 1'b0;
        repeat (3) begin @(posedge clk1); #1; end
        chk("stall_vout", valid_out, 1);
        chk("stall_index", out_index, 3);
        repeat (2) begin @(posedge clk1); #1; end
        out_ready = 1'b1;
        wait_idle(400);
`endif

        // Reset asserted mid-ACC
        load_vec(0, t);
        push_expect(t, -1, 0);
        wait_cyc(t + 15);
        chk("in_acc", acc_en, 1);
        #2;
        rst_n = 1'b0;
        q_out.delete();
        q_clr.delete();
        q_rw.delete();
        q_end.delete();
        #1;
        chk("async_reset_outputs", outvec, 0);
        @(posedge clk1); #1;
        @(posedge clk1); #1;
        release_reset();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
